systolic_feeder: RTL and testbench

- Upstream operand stage for the 8x8 output-stationary PE array.
- Buffers K beats of operands: one column of A and one row of B per beat.
- Replays them with the diagonal skew the array needs, so row i gets A delayed by i cycles and column j gets B delayed by j cycles.
- Pulses the array clear before each job and flags done once every PE has accumulated its last product.

---
 rtl/systolic_feeder.sv | 178 +++++++++++++++++
 tb/tb_systolic_feeder.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Operand feeder for the NxN output-stationary PE array: buffers K beats, replays them diagonally skewed.
// Optional FEEDER_DBUF_EN adds a second operand bank so the next job loads while the current one streams.
module systolic_feeder #(
   parameter int DATA_WIDTH = 8,
   parameter int N          = 8,
   parameter int K          = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N*DATA_WIDTH-1:0] a_col_in,
   input  logic [N*DATA_WIDTH-1:0] b_row_in,
   output logic [N*DATA_WIDTH-1:0] a_out,
   output logic [N*DATA_WIDTH-1:0] b_out,
   output logic                  array_clr,
   output logic                  busy,
   output logic                  done
);

   localparam int W  = N * DATA_WIDTH;
   localparam int CW = $clog2(K + 1);
   localparam int TW = $clog2(K + 2 * N);
`ifdef FEEDER_DBUF_EN
   localparam int NB = 2;
`else
   localparam int NB = 1;
`endif
   localparam int AW = (NB * K > 1) ? $clog2(NB * K) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CLEAR,
      S_STREAM,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t        state;
   state_t        ns;
   logic [CW-1:0] beat_cnt;
   logic [CW-1:0] cnt_n;
   logic [TW-1:0] tcnt;
   logic [TW-1:0] t_n;
   logic          wb;
   logic          rb;
   logic          swap;
   logic          acc;
   logic          rdy_d;
   logic [W-1:0]  a_nxt;
   logic [W-1:0]  b_nxt;
   logic [AW-1:0] waddr;

   logic [W-1:0] mem_a [NB*K];
   logic [W-1:0] mem_b [NB*K];

   function automatic logic in_win(input int k);
      return (k >= 0) && (k < K);
   endfunction

   assign acc   = in_valid & in_ready;
   assign waddr = AW'(int'(wb) * K + int'(beat_cnt));

   always_comb begin
      ns    = state;
      cnt_n = beat_cnt;
      t_n   = tcnt;
      swap  = 1'b0;
      if (acc) cnt_n = beat_cnt + CW'(1);
      unique case (state)
         S_IDLE: begin
            if (acc) ns = (K == 1) ? S_CLEAR : S_LOAD;
         end
         S_LOAD: begin
            if (acc && beat_cnt == CW'(K - 1)) ns = S_CLEAR;
         end
         S_CLEAR: begin
            ns  = S_STREAM;
            t_n = '0;
         end
         S_STREAM: begin
            if (tcnt == TW'(K + N - 2)) begin
               ns  = S_DRAIN;
               t_n = '0;
            end else begin
               t_n = tcnt + TW'(1);
            end
         end
         S_DRAIN: begin
            if (tcnt == TW'(N - 1)) begin
               ns  = S_DONE;
               t_n = '0;
            end else begin
               t_n = tcnt + TW'(1);
            end
         end
         S_DONE: begin
`ifdef FEEDER_DBUF_EN
            if (cnt_n == CW'(K))
               ns = S_CLEAR;
            else if (cnt_n != '0)
               ns = S_LOAD;
            else
               ns = S_IDLE;
`else
            ns = S_IDLE;
`endif
         end
         default: ns = S_IDLE;
      endcase
      // entering CLEAR hands the filled bank to the streamer
      if (ns == S_CLEAR) begin
         swap  = 1'b1;
         cnt_n = '0;
      end
      rdy_d = (ns == S_IDLE) || (ns == S_LOAD);
`ifdef FEEDER_DBUF_EN
      if (cnt_n < CW'(K)) rdy_d = 1'b1;
`endif
   end

   // lane i and lane j both read slot t-lane; the index window alone picks zero
   always_comb begin
      a_nxt = '0;
      b_nxt = '0;
      if (state == S_STREAM) begin
         for (int i = 0; i < N; i++) begin
            if (in_win(int'(tcnt) - i)) begin
               a_nxt[i*DATA_WIDTH +: DATA_WIDTH] =
                  mem_a[AW'(int'(rb) * K + int'(tcnt) - i)][i*DATA_WIDTH +: DATA_WIDTH];
               b_nxt[i*DATA_WIDTH +: DATA_WIDTH] =
                  mem_b[AW'(int'(rb) * K + int'(tcnt) - i)][i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         beat_cnt  <= '0;
         tcnt      <= '0;
         wb        <= 1'b0;
         rb        <= 1'b0;
         in_ready  <= 1'b0;
         a_out     <= '0;
         b_out     <= '0;
         array_clr <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state    <= ns;
         beat_cnt <= cnt_n;
         tcnt     <= t_n;
         if (swap) begin
            rb <= wb;
`ifdef FEEDER_DBUF_EN
            wb <= ~wb;
`endif
         end
         in_ready  <= rdy_d;
         a_out     <= a_nxt;
         b_out     <= b_nxt;
         array_clr <= (ns == S_CLEAR);
         busy      <= (ns != S_IDLE);
         done      <= (ns == S_DONE);
      end
   end

   always_ff @(posedge clk) begin
      if (acc) begin
         mem_a[waddr] <= a_col_in;
         mem_b[waddr] <= b_row_in;
      end
   end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: drives jobs, models an output-stationary PE array, checks lanes and products.
// Builds with or without FEEDER_DBUF_EN.
module tb_systolic_feeder;
   localparam int DW = 8;
   localparam int N  = 8;
   localparam int K  = 8;
   localparam int W  = N * DW;
   localparam int LAT = 1 + (K + N - 1) + N + 1;
`ifdef FEEDER_DBUF_EN
   localparam bit HOLD = 1'b0;
`else
   localparam bit HOLD = 1'b1;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a_col_in = '0;
   logic [W-1:0] b_row_in = '0;
   logic [W-1:0] a_out;
   logic [W-1:0] b_out;
   logic         array_clr;
   logic         busy;
   logic         done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int ma [2][N][K];
   int mb [2][K][N];
   int pc [N][N];
   int pa [N][N];
   int pb [N][N];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   systolic_feeder #(.DATA_WIDTH(DW), .N(N), .K(K)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a_col_in(a_col_in), .b_row_in(b_row_in), .a_out(a_out), .b_out(b_out),
      .array_clr(array_clr), .busy(busy), .done(done)
   );

   function automatic int pe_a(int i, int j);
      return (j == 0) ? int'(a_out[i*DW +: DW]) : pa[i][j-1];
   endfunction

   function automatic int pe_b(int i, int j);
      return (i == 0) ? int'(b_out[j*DW +: DW]) : pb[i-1][j];
   endfunction

   // PE array: a moves right, b moves down, c accumulates, array_clr is its reset
   always @(posedge clk) begin
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            if (array_clr === 1'b1) begin
               pc[i][j] <= 0;
               pa[i][j] <= 0;
               pb[i][j] <= 0;
            end else begin
               pc[i][j] <= pc[i][j] + pe_a(i, j) * pe_b(i, j);
               pa[i][j] <= pe_a(i, j);
               pb[i][j] <= pe_b(i, j);
            end
         end
   end

   function automatic logic [W-1:0] lanes_a(int jb, int t);
      logic [W-1:0] v = '0;
      for (int i = 0; i < N; i++)
         if (t - i >= 0 && t - i < K) v[i*DW +: DW] = DW'(ma[jb][i][t-i]);
      return v;
   endfunction

   function automatic logic [W-1:0] lanes_b(int jb, int t);
      logic [W-1:0] v = '0;
      for (int j = 0; j < N; j++)
         if (t - j >= 0 && t - j < K) v[j*DW +: DW] = DW'(mb[jb][t-j][j]);
      return v;
   endfunction

   function automatic logic [W-1:0] pack_a(int jb, int k);
      logic [W-1:0] v = '0;
      for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(ma[jb][i][k]);
      return v;
   endfunction

   function automatic logic [W-1:0] pack_b(int jb, int k);
      logic [W-1:0] v = '0;
      for (int j = 0; j < N; j++) v[j*DW +: DW] = DW'(mb[jb][k][j]);
      return v;
   endfunction

   function automatic logic exp_ready(int m);
`ifdef FEEDER_DBUF_EN
      return 1'b1;
`else
      return m > LAT;
`endif
   endfunction

   task automatic fill(input int jb, input int mode);
      for (int i = 0; i < N; i++)
         for (int k = 0; k < K; k++) begin
            case (mode)
               0: begin ma[jb][i][k] = (i == k) ? 1 : 0; mb[jb][k][i] = 8 * k + i + 1; end
               1: begin ma[jb][i][k] = 1; mb[jb][k][i] = 1; end
               2: begin ma[jb][i][k] = 255; mb[jb][k][i] = 255; end
               default: begin
                  ma[jb][i][k] = int'($urandom_range(0, 255));
                  mb[jb][k][i] = int'($urandom_range(0, 255));
               end
            endcase
         end
   endtask

   task automatic check_prod(input string nm, input int jb);
      int bad, r, fi, fj, fv, fr;
      bad = 0; fi = 0; fj = 0; fv = 0; fr = 0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            r = 0;
            for (int k = 0; k < K; k++) r += ma[jb][i][k] * mb[jb][k][j];
            if (pc[i][j] != r) begin
               if (bad == 0) begin fi = i; fj = j; fv = pc[i][j]; fr = r; end
               bad++;
            end
         end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL %s product: %0d bad, c(%0d,%0d) got %0d want %0d", nm, bad, fi, fj, fv, fr);
      end
   endtask

   task automatic send_job(input int jb, input bit stall, output int first_c, output int last_c);
      int k, guard;
      bit ph, rdy;
      k = 0; guard = 0; ph = 1'b0; first_c = -1; last_c = -1;
      while (k < K && guard < 200) begin
         @(negedge clk);
         guard++;
         if (stall && ph) begin
            in_valid = 1'b0;
         end else begin
            in_valid = 1'b1;
            a_col_in = pack_a(jb, k);
            b_row_in = pack_b(jb, k);
         end
         ph  = stall ? ~ph : 1'b0;
         rdy = in_ready;
         @(posedge clk);
         if (in_valid && rdy) begin
            if (k == 0) first_c = cyc;
            last_c = cyc;
            k++;
         end
      end
      if (k < K) begin
         checks++; errors++;
         $display("FAIL load timeout: %0d beats accepted, want %0d", k, K);
         $display("Simulation finished: %0d checks, %0d errors", checks, errors);
         $fatal(1, "load timeout");
      end
   endtask

   // m counts edges since the edge that accepted the last beat
   task automatic check_job(input string nm, input int jb, input int last_m, input bit hold);
      logic [W-1:0] ea, eb;
      logic [3:0] ec;
      for (int m = 1; m <= last_m; m++) begin
         @(negedge clk);
         ea = lanes_a(jb, m - 3);
         eb = lanes_b(jb, m - 3);
         ec = {exp_ready(m), m <= LAT, m == LAT, m == 1};
         checks++;
         if (a_out !== ea) begin
            errors++;
            $display("FAIL %s a_out m=%0d got %h want %h", nm, m, a_out, ea);
         end
         checks++;
         if (b_out !== eb) begin
            errors++;
            $display("FAIL %s b_out m=%0d got %h want %h", nm, m, b_out, eb);
         end
         checks++;
         if ({in_ready, busy, done, array_clr} !== ec) begin
            errors++;
            $display("FAIL %s ctrl(rdy,busy,done,clr) m=%0d got %b want %b",
                     nm, m, {in_ready, busy, done, array_clr}, ec);
         end
         if (m == LAT) check_prod(nm, jb);
         if (hold && m < last_m) begin
            in_valid = 1'b1;
            a_col_in = {$urandom, $urandom};
            b_row_in = {$urandom, $urandom};
         end else begin
            in_valid = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({in_ready, busy, done, array_clr} !== 4'b0001 || a_out !== '0 || b_out !== '0) begin
         errors++;
         $display("FAIL reset: ctrl %b a %h b %h want 0001/0/0",
                  {in_ready, busy, done, array_clr}, a_out, b_out);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({in_ready, busy, done, array_clr} !== 4'b1000) begin
         errors++;
         $display("FAIL idle: ctrl %b want 1000", {in_ready, busy, done, array_clr});
      end
   endtask

   task automatic test_identity();
      int f, l, bad;
      fill(0, 0);
      send_job(0, 1'b0, f, l);
      checks++;
      if (l - f != K - 1) begin
         errors++;
         $display("FAIL ident load span got %0d want %0d", l - f, K - 1);
      end
      check_job("ident", 0, LAT + 1, HOLD);
      bad = 0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            if (pc[i][j] != 8 * i + j + 1) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL ident c=8i+j+1: %0d entries wrong, want 0", bad);
      end
   endtask

   task automatic test_ones();
      int f, l, bad;
      fill(0, 1);
      send_job(0, 1'b0, f, l);
      check_job("ones", 0, LAT + 1, 1'b0);
      bad = 0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            if (pc[i][j] != K) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL ones c=8: %0d entries wrong, want 0", bad);
      end
   endtask

   task automatic test_stall();
      int f, l;
      fill(0, 0);
      send_job(0, 1'b1, f, l);
      checks++;
      if (l - f != 2 * (K - 1)) begin
         errors++;
         $display("FAIL stall load span got %0d want %0d", l - f, 2 * (K - 1));
      end
      check_job("stall", 0, LAT + 1, HOLD);
   endtask

   task automatic test_mid_reset();
      int f, l;
      fill(0, 3);
      send_job(0, 1'b0, f, l);
      check_job("midrst", 0, 7, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({in_ready, busy, done, array_clr} !== 4'b0001 || a_out !== '0 || b_out !== '0) begin
         errors++;
         $display("FAIL midrst: ctrl %b a %h b %h want 0001/0/0",
                  {in_ready, busy, done, array_clr}, a_out, b_out);
      end
      rst = 1'b0;
      @(negedge clk);
      fill(0, 3);
      send_job(0, 1'b0, f, l);
      check_job("reload", 0, LAT + 1, 1'b0);
   endtask

   task automatic test_full_scale();
      int f, l, bad;
      fill(0, 2);
      send_job(0, 1'b0, f, l);
      check_job("full", 0, LAT + 1, 1'b0);
      bad = 0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            if (pc[i][j] != 520200) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL full c=520200: %0d entries wrong, want 0", bad);
      end
   endtask

   task automatic test_back_to_back();
      int f, l;
      for (int r = 0; r < 3; r++) begin
         fill(0, 3);
         send_job(0, 1'b0, f, l);
         check_job("b2b", 0, LAT + 1, HOLD);
      end
   endtask

`ifdef FEEDER_DBUF_EN
   task automatic test_dbuf();
      int f, l, k2, acc_c, jb, t;
      bit rdy_s;
      logic [W-1:0] ea, eb;
      fill(0, 3);
      fill(1, 3);
      send_job(0, 1'b0, f, l);
      k2 = 0; acc_c = -1; rdy_s = 1'b0;
      for (int m = 1; m <= 2 * LAT + 1; m++) begin
         @(negedge clk);
         if (in_valid && rdy_s && m > 2) begin
            if (k2 == K - 1) acc_c = m - 1;
            k2++;
         end
         jb = (m <= LAT) ? 0 : 1;
         t  = (m <= LAT) ? m - 3 : m - 3 - LAT;
         ea = lanes_a(jb, t);
         eb = lanes_b(jb, t);
         checks++;
         if (a_out !== ea || b_out !== eb) begin
            errors++;
            $display("FAIL dbuf lanes m=%0d got %h/%h want %h/%h", m, a_out, b_out, ea, eb);
         end
         checks++;
         if ({done, array_clr} !== {m == LAT || m == 2 * LAT, m == 1 || m == LAT + 1}) begin
            errors++;
            $display("FAIL dbuf done/clr m=%0d got %b", m, {done, array_clr});
         end
         if (m == LAT) check_prod("dbuf job1", 0);
         if (m == 2 * LAT) check_prod("dbuf job2", 1);
         rdy_s = in_ready;
         if (m >= 2 && k2 < K) begin
            in_valid = 1'b1;
            a_col_in = pack_a(1, k2);
            b_row_in = pack_b(1, k2);
         end else begin
            in_valid = 1'b0;
         end
      end
      checks++;
      if (k2 != K || acc_c < 2 || acc_c > K + N) begin
         errors++;
         $display("FAIL dbuf preload: %0d beats, last at m=%0d, want %0d within stream", k2, acc_c, K);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_identity();
      test_ones();
      test_stall();
      test_mid_reset();
      test_full_scale();
      test_back_to_back();
`ifdef FEEDER_DBUF_EN
      test_dbuf();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
